// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between NUM_REQ cores.
// Core 0 occupies the most-significant position of every per-core bus (bits and slices alike).
module dmem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_en,
  input  logic [NUM_REQ-1:0]               req_wr_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             mem_en,
  output logic                             mem_wr_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int PW = $clog2(NUM_REQ);
  typedef logic [PW-1:0] idx_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
    $error("dmem_arbiter: NUM_REQ must be a power of two in 2..8");
  end

  // Core-indexed views of the packed request buses (index i == core i).
  logic [NUM_REQ-1:0]    en_c;
  logic [NUM_REQ-1:0]    wr_c;
  logic [ADDR_WIDTH-1:0] addr_c  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_c [NUM_REQ];
  logic [NUM_REQ-1:0]    gnt_c;

  idx_t                  ptr_q, ptr_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]    rd_pend_q, rd_pend_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_core
    assign en_c[i]    = req_en[NUM_REQ-1-i];
    assign wr_c[i]    = req_wr_en[NUM_REQ-1-i];
    assign addr_c[i]  = req_addr[(NUM_REQ-1-i)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_c[i] = req_wdata[(NUM_REQ-1-i)*DATA_WIDTH +: DATA_WIDTH];
    assign gnt[NUM_REQ-1-i]    = gnt_c[i];
    assign rvalid[NUM_REQ-1-i] = rvalid_q[i];
  end

  // Scan from ptr upward; idx_t arithmetic wraps modulo NUM_REQ for free.
  idx_t win;
  idx_t scan;
  logic found;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    win   = ptr_q;
    scan  = ptr_q;
    gnt_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = ptr_q + idx_t'(k);
      if (!found && en_c[scan]) begin
        found = 1'b1;
        win   = scan;
      end
    end
    if (reset) found = 1'b0;
    if (found) gnt_c[win] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    mem_en_d    = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_pend_d   = '0;
    rvalid_d    = rd_pend_q;
    if (found) begin
      mem_en_d    = 1'b1;
      mem_wr_en_d = wr_c[win];
      mem_addr_d  = addr_c[win];
      mem_wdata_d = wdata_c[win];
      ptr_d       = win + idx_t'(1);
      if (!wr_c[win]) rd_pend_d[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= '0;
      rvalid_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares one single-ported data memory between `NUM_REQ` four-stage processor cores in the mesh node cluster. Each core presents its memory-enable/write-enable/address/data request; the arbiter grants at most one per cycle, registers the winning access onto the memory port, and routes read data back to the winner with a valid pulse. Throughput is one access per cycle. Losing cores hold their request until granted.

## Interface
- `NUM_REQ`, 4: number of requesting cores; must be a power of two, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 64: data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_en`  in  NUM_REQ  bit i set means core i requests an access.
- `req_wr_en`  in  NUM_REQ  bit i set means core i's request is a write; ignored when `req_en[i]` is low.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  core i's address in slice i; slice 0 is the most-significant slice.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  core i's write data in slice i.
- `gnt`  out  NUM_REQ  one-hot combinational grant for the current cycle.
- `rvalid`  out  NUM_REQ  one-hot registered read-return strobe.
- `rdata`  out  DATA_WIDTH  read data, broadcast to all cores; qualified by `rvalid`.
- `mem_en`  out  1  memory enable, registered.
- `mem_wr_en`  out  1  memory write enable, registered.
- `mem_addr`  out  ADDR_WIDTH  memory address, registered.
- `mem_wdata`  out  DATA_WIDTH  memory write data, registered.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid in the cycle after a read is presented.

## Operation
- State:
  - Round-robin pointer `ptr`, log2(NUM_REQ) bits.
  - Memory-side output registers.
  - One-hot read-pending register `rd_pend`, NUM_REQ bits.
- Grant, combinational:
  - Scan `req_en` starting at index `ptr`, then `ptr+1` upward modulo NUM_REQ.
  - The first set bit wins and `gnt` is one-hot at that index.
  - `gnt` is all-zero when `req_en` is zero.
- On each rising edge when not in reset:
  - If a grant exists for winner w:
    - `mem_en` <= 1.
    - `mem_wr_en` <= `req_wr_en[w]`.
    - `mem_addr` <= slice w of `req_addr`.
    - `mem_wdata` <= slice w of `req_wdata`.
    - `ptr` <= (w+1) mod NUM_REQ.
  - If no grant exists:
    - `mem_en` and `mem_wr_en` <= 0.
    - `mem_addr` and `mem_wdata` hold their values.
    - `ptr` holds.
  - `rd_pend` <= one-hot(w) if the registered access is a read; otherwise `rd_pend` <= 0.
  - `rvalid` <= `rd_pend`.
- `rdata` = `mem_rdata` passed through combinationally. Its value is don't-care when `rvalid` is zero.
- A request is consumed in the cycle its `gnt` bit is high. If the core keeps `req_en` high afterwards, the arbiter treats it as a new request.
- Writes produce no `rvalid`.
- The arbiter is address-agnostic. NIC-space decoding stays in the core.
- Reset:
  - `ptr`, `rd_pend`, `rvalid`, `mem_en`, `mem_wr_en`, `mem_addr` and `mem_wdata` all clear to 0.
  - `gnt` is forced to 0 while `reset` is high.
  - A read in flight at reset is dropped; no `rvalid` is ever produced for it.

## Timing
- Request granted in cycle C: `gnt` is high in C. `mem_*` carries the access in C+1.
- For a read, `rvalid[w]` is high in C+2 and `rdata` carries `mem_rdata` in C+2.
- Grant latency: 0 cycles when uncontested. Worst case with all cores requesting continuously: NUM_REQ-1 cycles.
- Back-to-back grants are allowed every cycle, including to the same core when it is the only requester. In that case `ptr` advances past it each cycle, but the scan wraps back to it.
- `ptr` wraps from NUM_REQ-1 to 0.
- `req_wr_en` toggling with `req_en` low: no effect.
- Reset asserted in cycle C: every registered output is 0 in C+1, and `gnt` is 0 during C.

## Test plan
- Reset then idle: `req_en`=0 for 5 cycles. Expect `gnt`=0, `mem_en`=0, `rvalid`=0 throughout.
- Single read: core 2 reads addr 0x10 in cycle C while memory holds 0xDEADBEEF00000001. Expect:
  - `gnt`=0010 in C.
  - `mem_en`=1, `mem_wr_en`=0, `mem_addr`=0x10 in C+1.
  - `rvalid`=0010 and `rdata`=0xDEADBEEF00000001 in C+2.
- Full contention: all four cores hold `req_en` from `ptr`=0, each dropping its request after its grant. Expect:
  - Grants in the order 1000, 0100, 0010, 0001 on consecutive cycles.
  - `ptr` returns to 0.
- Rotation fairness: cores 0 and 3 hold requests continuously for 8 cycles. Expect grants to alternate 0,3,0,3,…, with neither core granted twice in a row.
- Write then read, same address: core 1 writes 0x5 to addr 0x20, then core 1 reads 0x20 on the next cycle. Expect:
  - `mem_wr_en`=1 with `mem_wdata`=0x5 in the first memory cycle.
  - `rvalid`=0100 with `rdata`=0x5 two cycles after the read grant.
  - No `rvalid` for the write.
- Reset mid-read: read granted in C, `reset` high in C+1. Expect `rvalid`=0 in C+2, `mem_en`=0 in C+2, and `ptr`=0.
